// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: drives a 2-input gate under test through all four input
// vectors {in2,in1} = 00,01,10,11, holds each for SETTLE_CYCLES, samples the
// gate output in the last settle cycle and compares it against EXPECTED.
// Reports a one-cycle done pulse, a pass flag and a per-vector fail mask.
// Optional feature macro: GATE_SWEEP_LOOP_EN (adds loop_en / sweep_cnt for
// back-to-back sweeps with an accumulated fail mask).
`timescale 1ns/1ps

module gate_sweep_ctrl #(
  parameter int         SETTLE_CYCLES = 1,
  parameter logic [3:0] EXPECTED      = 4'b1001,
  parameter bit         STOP_ON_FAIL  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       gate_out,
  output logic       drv_in1,
  output logic       drv_in2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [1:0] vec_idx
`ifdef GATE_SWEEP_LOOP_EN
  ,
  input  logic       loop_en,
  output logic [7:0] sweep_cnt
`endif
);

  localparam int            CW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  logic       sample_bad;
  logic       last_cnt;
  logic       accept;
  logic       finish;
  logic       loop_go;
  logic [3:0] mask_next;

  // NOTE: helper terms are continuous assigns, so no always_comb default-assignment is needed to avoid latches.
  assign sample_bad = (gate_out != EXPECTED[vec_idx]);
  assign last_cnt   = (cnt == CNT_LAST);
  assign mask_next  = fail_mask | ({3'b000, sample_bad} << vec_idx);
  assign accept     = (state == IDLE) && start && !abort;
  // Sweep ends on the last sample of vector 3, or on the first mismatch when stopping early.
  assign finish     = (state == DRIVE) && !abort && last_cnt &&
                      ((vec_idx == 2'd3) || (STOP_ON_FAIL && sample_bad));

`ifdef GATE_SWEEP_LOOP_EN
  assign loop_go = loop_en;
`else
  assign loop_go = 1'b0;
`endif

  // Sweep sequencer: state, settle counter and all registered outputs.
  // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      drv_in1   <= 1'b0;
      drv_in2   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_mask <= 4'b0000;
      vec_idx   <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          done    <= 1'b0;
          drv_in1 <= 1'b0;
          drv_in2 <= 1'b0;
          busy    <= 1'b0;
          if (accept) begin
            state     <= DRIVE;
            busy      <= 1'b1;
            vec_idx   <= 2'd0;
            cnt       <= '0;
            fail_mask <= 4'b0000;
            pass      <= 1'b0;
          end
        end

        DRIVE: begin
          if (abort) begin
            // Cancelled sweeps leave no result behind.
            state     <= IDLE;
            busy      <= 1'b0;
            drv_in1   <= 1'b0;
            drv_in2   <= 1'b0;
            fail_mask <= 4'b0000;
            pass      <= 1'b0;
            vec_idx   <= 2'd0;
            cnt       <= '0;
          end else if (last_cnt) begin
            fail_mask <= mask_next;
            cnt       <= '0;
            if (finish) begin
              state   <= DONE;
              done    <= 1'b1;
              pass    <= ~|mask_next;
              busy    <= loop_go;
              drv_in1 <= 1'b0;
              drv_in2 <= 1'b0;
            end else begin
              vec_idx            <= vec_idx + 2'd1;
              {drv_in2, drv_in1} <= vec_idx + 2'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        DONE: begin
          // abort is deliberately ignored here: the result is already committed.
          done    <= 1'b0;
          vec_idx <= 2'd0;
          cnt     <= '0;
          if (loop_go) begin
            state <= DRIVE;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef GATE_SWEEP_LOOP_EN
  // Completed-sweep counter: bumps on each entry to DONE, cleared on a new start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sweep_cnt <= 8'd0;
    end else if (accept) begin
      sweep_cnt <= 8'd0;
    end else if (finish) begin
      sweep_cnt <= sweep_cnt + 8'd1;
    end
  end
`endif

endmodule
